// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port ram8x64k between two requesters.
// Each cycle it accepts at most one command, using a combinational grant.
// A requester can lock the grant for bursts of up to MAX_BURST commands.
// Read data comes back one cycle after the accept. rspN_valid steers it
// to the requester that issued the read.
// Build option: define RAM_ARB_RR_EN to resolve contention round-robin
// using the last winner. With it undefined, req0 has fixed priority.
module ram_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // burst_cnt has to hold every value from 0 to MAX_BURST.
    localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_r;        // last winner: 1'b0 = req0, 1'b1 = req1
    logic             last_nxt_s;
    logic [CNT_W-1:0] burst_cnt_r;
    logic [CNT_W-1:0] burst_nxt_s;
    logic [1:0]       rd_pend_r;
    logic [1:0]       rd_pend_nxt_s;

    logic             hold0_s;
    logic             hold1_s;
    logic             grant0_s;
    logic             grant1_s;

    // Grant decision: the lock owner keeps the grant while its burst has room; otherwise arbitrate.
    always_comb begin
        hold0_s  = (state_r == ST_OWN0) && req0_valid && (burst_cnt_r < BURST_MAX);
        hold1_s  = (state_r == ST_OWN1) && req1_valid && (burst_cnt_r < BURST_MAX);
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst_n) begin
            // Nothing is accepted while reset is asserted.
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (hold0_s) begin
            grant0_s = 1'b1;
        end else if (hold1_s) begin
            grant1_s = 1'b1;
        end else if (req0_valid && req1_valid) begin
`ifdef RAM_ARB_RR_EN
            // Contention goes to the requester that did not win last.
            if (last_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
`else
            // Fixed priority: req0 always wins contention.
            grant0_s = 1'b1;
`endif
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // A grant is only issued to a valid requester, so ready equals grant.
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Drive the RAM port from the winner; park it at zero when nothing is accepted.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = {ADDR_W{1'b0}};
        ram_din  = {DATA_W{1'b0}};
        if (grant0_s) begin
            ram_we   = req0_we;
            ram_addr = req0_addr;
            ram_din  = req0_wdata;
        end else if (grant1_s) begin
            ram_we   = req1_we;
            ram_addr = req1_addr;
            ram_din  = req1_wdata;
        end else begin
            ram_we   = 1'b0;
            ram_addr = {ADDR_W{1'b0}};
            ram_din  = {DATA_W{1'b0}};
        end
    end

    // Next-state logic for ownership, burst count, RR pointer and read tracking.
    always_comb begin
        state_nxt_s   = ST_IDLE;
        burst_nxt_s   = CNT_ZERO;
        last_nxt_s    = last_r;
        rd_pend_nxt_s = 2'b00;
        case ({grant1_s, grant0_s})
            2'b01: begin
                last_nxt_s    = 1'b0;
                rd_pend_nxt_s = {1'b0, ~req0_we};
                if (req0_lock) begin
                    state_nxt_s = ST_OWN0;
                    // Keep counting only while the same burst goes on. When the count
                    // is full, re-arbitration has already happened, so a new burst starts.
                    if ((state_r == ST_OWN0) && (burst_cnt_r < BURST_MAX)) begin
                        burst_nxt_s = burst_cnt_r + CNT_ONE;
                    end else begin
                        burst_nxt_s = CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    burst_nxt_s = CNT_ZERO;
                end
            end
            2'b10: begin
                last_nxt_s    = 1'b1;
                rd_pend_nxt_s = {~req1_we, 1'b0};
                if (req1_lock) begin
                    state_nxt_s = ST_OWN1;
                    if ((state_r == ST_OWN1) && (burst_cnt_r < BURST_MAX)) begin
                        burst_nxt_s = burst_cnt_r + CNT_ONE;
                    end else begin
                        burst_nxt_s = CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    burst_nxt_s = CNT_ZERO;
                end
            end
            default: begin
                // No accept: any lock is lost and the burst ends.
                state_nxt_s   = ST_IDLE;
                burst_nxt_s   = CNT_ZERO;
                last_nxt_s    = last_r;
                rd_pend_nxt_s = 2'b00;
            end
        endcase
    end

    // State registers. After reset req0 is favoured, so last points at req1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            burst_cnt_r <= CNT_ZERO;
            rd_pend_r   <= 2'b00;
        end else begin
            state_r     <= state_nxt_s;
            last_r      <= last_nxt_s;
            burst_cnt_r <= burst_nxt_s;
            rd_pend_r   <= rd_pend_nxt_s;
        end
    end

    // rd_pend already lines up with the RAM's registered read data.
    // Responses are also held off while reset is asserted.
    assign rsp0_valid = rd_pend_r[0] & rst_n;
    assign rsp1_valid = rd_pend_r[1] & rst_n;
    assign rsp0_rdata = ram_dout;
    assign rsp1_rdata = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter. It uses a behavioural 64K x 8 RAM
// (synchronous write, registered read). The RAM is preloaded with
// mem[a] = a[7:0] ^ 8'h5A, so 0x1234 holds 0x6E.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we, req0_lock;
    logic [15:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        rsp0_valid;
    logic [7:0]  rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, req1_lock;
    logic [15:0] req1_addr;
    logic [7:0]  req1_wdata;
    logic        rsp1_valid;
    logic [7:0]  rsp1_rdata;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    logic [7:0]  mem [0:65535];

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural ram8x64k: write at the edge, registered read of the old contents.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set0(input logic v, input logic we, input logic lk, input logic [15:0] a, input logic [7:0] d);
        req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic lk, input logic [15:0] a, input logic [7:0] d);
        req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set1(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int prev;
        int exp_g;
        int k;
        int n_seq;
        int exp_seq [7];

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        rst_n = 1'b0;
        set0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set1(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        next_cycle();

        // Reset held with both requesters active.
        set0(1'b1, 1'b1, 1'b0, 16'h0001, 8'h11);
        set1(1'b1, 1'b0, 1'b0, 16'h0002, 8'h00);
        @(negedge clk);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_rsp0", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1", 32'(rsp1_valid), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        set1(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);

        // Solo write 0xA5 to 0xFFFF, then read it back.
        set0(1'b1, 1'b1, 1'b0, 16'hFFFF, 8'hA5);
        @(negedge clk);
        check("wr_ready0", 32'(req0_ready), 32'd1);
        check("wr_ready1", 32'(req1_ready), 32'd0);
        check("wr_ram_we", 32'(ram_we), 32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'hFFFF);
        check("wr_ram_din", 32'(ram_din), 32'hA5);
        next_cycle();
        set0(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00);
        @(negedge clk);
        check("rd_ready0", 32'(req0_ready), 32'd1);
        check("rd_ram_we", 32'(ram_we), 32'd0);
        check("rd_ram_addr", 32'(ram_addr), 32'hFFFF);
        check("wr_no_rsp0", 32'(rsp0_valid), 32'd0);
        next_cycle();
        set0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        check("rd_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("rd_rsp0_data", 32'(rsp0_rdata), 32'hA5);
        check("rd_rsp1_quiet", 32'(rsp1_valid), 32'd0);
        check("idle_ram_addr", 32'(ram_addr), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rd_rsp0_once", 32'(rsp0_valid), 32'd0);
        next_cycle();

        // Contention: both read continuously without lock.
        do_reset();
        set0(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00);
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            exp_g = RR ? (i % 2) : 0;
            @(negedge clk);
            check("cont_ready0", 32'(req0_ready), 32'(exp_g == 0));
            check("cont_ready1", 32'(req1_ready), 32'(exp_g == 1));
            check("cont_rsp0", 32'(rsp0_valid), 32'(prev == 0));
            check("cont_rsp1", 32'(rsp1_valid), 32'(prev == 1));
            if (prev == 0) check("cont_rdata0", 32'(rsp0_rdata), 32'hA5);
            if (prev == 1) check("cont_rdata1", 32'(rsp1_rdata), 32'h6E);
            prev = exp_g;
            next_cycle();
        end

        // Locked burst of six writes by req0 while req1 keeps reading 0x1234.
        do_reset();
        if (RR) begin
            exp_seq = '{0, 0, 0, 0, 1, 0, 0};
            n_seq = 7;
        end else begin
            exp_seq = '{0, 0, 0, 0, 0, 0, 0};
            n_seq = 6;
        end
        k = 0;
        prev = -1;
        set1(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00);
        for (int c = 0; c < n_seq; c++) begin
            set0(1'b1, 1'b1, 1'b1, 16'h8000 + 16'(k), 8'h10 + 8'(k));
            @(negedge clk);
            check("bst_ready0", 32'(req0_ready), 32'(exp_seq[c] == 0));
            check("bst_ready1", 32'(req1_ready), 32'(exp_seq[c] == 1));
            check("bst_rsp1", 32'(rsp1_valid), 32'(prev == 1));
            if (prev == 1) check("bst_rdata1", 32'(rsp1_rdata), 32'h6E);
            if (exp_seq[c] == 0) begin
                check("bst_ram_we", 32'(ram_we), 32'd1);
                check("bst_ram_addr", 32'(ram_addr), 32'h8000 + 32'(k));
                k++;
            end else begin
                check("bst_ram_we1", 32'(ram_we), 32'd0);
                check("bst_ram_addr1", 32'(ram_addr), 32'h1234);
            end
            prev = exp_seq[c];
            next_cycle();
        end
        set1(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        // Pipelined readback of the six written bytes.
        for (int j = 0; j < 7; j++) begin
            if (j < 6) set0(1'b1, 1'b0, 1'b0, 16'h8000 + 16'(j), 8'h00);
            else       set0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
            @(negedge clk);
            check("rb_rsp0", 32'(rsp0_valid), 32'(j > 0));
            if (j > 0) check("rb_rdata0", 32'(rsp0_rdata), 32'h10 + 32'(j - 1));
            next_cycle();
        end

        // Lock release: the req0 owner drops valid, and req1 takes the grant that same cycle.
        do_reset();
        set0(1'b1, 1'b0, 1'b1, 16'hFFFF, 8'h00);
        set1(1'b1, 1'b0, 1'b1, 16'h1234, 8'h00);
        @(negedge clk);
        check("rel_c1_ready0", 32'(req0_ready), 32'd1);
        check("rel_c1_ready1", 32'(req1_ready), 32'd0);
        next_cycle();
        set0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        check("rel_c2_ready1", 32'(req1_ready), 32'd1);
        check("rel_c2_ready0", 32'(req0_ready), 32'd0);
        check("rel_c2_rsp0", 32'(rsp0_valid), 32'd1);
        check("rel_c2_rdata0", 32'(rsp0_rdata), 32'hA5);
        next_cycle();
        set0(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00);
        @(negedge clk);
        check("rel_c3_hold1", 32'(req1_ready), 32'd1);
        check("rel_c3_ready0", 32'(req0_ready), 32'd0);
        check("rel_c3_rsp1", 32'(rsp1_valid), 32'd1);
        check("rel_c3_rdata1", 32'(rsp1_rdata), 32'h6E);
        next_cycle();
        set1(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00);
        @(negedge clk);
        check("rel_c4_hold1", 32'(req1_ready), 32'd1);
        next_cycle();
        @(negedge clk);
        check("rel_c5_ready0", 32'(req0_ready), 32'd1);
        check("rel_c5_ready1", 32'(req1_ready), 32'd0);
        next_cycle();

        // Reset in the middle of a locked req1 read stream.
        set0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set1(1'b1, 1'b0, 1'b1, 16'h1234, 8'h00);
        @(negedge clk);
        check("mid_a_ready1", 32'(req1_ready), 32'd1);
        check("mid_a_rsp0", 32'(rsp0_valid), 32'd1);
        next_cycle();
        @(negedge clk);
        check("mid_b_ready1", 32'(req1_ready), 32'd1);
        check("mid_b_rsp1", 32'(rsp1_valid), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready1", 32'(req1_ready), 32'd0);
        check("mid_rst_rsp1", 32'(rsp1_valid), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00);
        @(negedge clk);
        check("post_rst_rsp1", 32'(rsp1_valid), 32'd0);
        check("post_rst_ready0", 32'(req0_ready), 32'd1);
        check("post_rst_ready1", 32'(req1_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        check("post_rsp0", 32'(rsp0_valid), 32'd1);
        check("post_rdata0", 32'(rsp0_rdata), 32'hA5);
        check("post_ready1", 32'(req1_ready), RR ? 32'd1 : 32'd0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port `ram8x64k` (8-bit data, 16-bit address, synchronous write, one-cycle registered read) between two masters. It sits directly in front of the RAM's `clk/we/addr/din/dout` port, accepts one command per cycle through valid/ready handshakes, and supports locked bursts. It routes each read response back to the requester that issued it, with fixed one-cycle latency.

## Interface
- `ADDR_W`, 16, RAM address width.
- `DATA_W`, 8, RAM data width.
- `MAX_BURST`, 4, maximum consecutive locked grants to one requester, at least 1.

Ports:
- `clk`  in  1  single clock; everything samples on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `reqN_valid`  in  1  requester N (N=0,1) command valid.
- `reqN_ready`  out  1  command accepted this cycle; combinational grant.
- `reqN_we`  in  1  1 = write, 0 = read.
- `reqN_lock`  in  1  requests that the grant be kept for the next command.
- `reqN_addr`  in  ADDR_W  command address.
- `reqN_wdata`  in  DATA_W  write data.
- `rspN_valid`  out  1  read data for requester N is on `rspN_rdata`.
- `rspN_rdata`  out  DATA_W  read data; equals `ram_dout`.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_din`  out  DATA_W  to RAM `din`.
- `ram_dout`  in  DATA_W  from RAM `dout`.

## Operation
- The FSM has three states: `IDLE` (no owner), `OWN0`, `OWN1`. Registers: FSM state, RR pointer `last` (last winner), `burst_cnt` (0..MAX_BURST), and `rd_pend[1:0]`.
- Grant is decided combinationally each cycle:
  - In `OWNn`, if `reqn_valid` is high and `burst_cnt < MAX_BURST`, requester n is granted. The other requester is blocked.
  - Otherwise the block arbitrates:
    - If only one requester is valid, it is granted.
    - If both are valid, the requester that is not `last` is granted.
    - If neither is valid, there is no grant.
- Accept = `reqN_valid & reqN_ready`. At most one `reqN_ready` is high per cycle. `ready` is never high without `valid`.
- RAM drive:
  - On accept: `ram_addr`/`ram_din` come from the winner, and `ram_we` = winner's `we`.
  - With no accept: `ram_we`=0, `ram_addr`=0, `ram_din`=0.
- State update on accept by N:
  - `last`←N.
  - If `reqN_lock` is 1: go to `OWNN`. `burst_cnt`←1 if the owner changed or the state was `IDLE`, otherwise `burst_cnt`+1.
  - If `reqN_lock` is 0: go to `IDLE` and set `burst_cnt`←0.
- With no accept: go to `IDLE` and set `burst_cnt`←0. An owner that drops `valid` loses the lock.
- When `burst_cnt` reaches MAX_BURST, the next cycle re-arbitrates. If the other requester is valid, it wins.
- Responses:
  - `rd_pend[N]` is set on a read accept by N and cleared otherwise.
  - `rspN_valid` = `rd_pend[N]`.
  - Writes produce no response.
- Both `rspN_rdata` outputs pass `ram_dout` through. Each is meaningful only while its `rspN_valid` is high.
- Read-after-write to the same address in back-to-back cycles returns the new data, per RAM write-then-read ordering.

## Timing
- Reset (`rst_n`=0 at an edge): state `IDLE`, `last`=1 (req0 favoured first), `burst_cnt`=0, `rd_pend`=0.
  - During reset, `reqN_ready`=0, `ram_we`=0, and `rspN_valid`=0.
  - A read accepted in the cycle reset asserts produces no response.
- Command throughput is one accept per cycle, with no bubble when switching requesters.
- Read latency: accept at edge k gives `rspN_valid`=1 and data valid during the cycle after edge k, exactly one cycle.
- Write takes effect in the RAM at the accept edge.
- Pipelined reads are allowed every cycle, each returning one cycle later, in order.

## Configuration
- `RAM_ARB_RR_EN` defined: contention (both valid, no lock in effect) is resolved round-robin using `last`, as described above.
- `RAM_ARB_RR_EN` undefined:
  - Fixed priority: req0 always wins contention.
  - Lock and MAX_BURST rules are unchanged. After a req1 burst ends with both valid, req0 wins.
  - The `last` register is still maintained but is not used for grant.

## Test plan
- Solo write then read: req0 writes 0xA5 to 0xFFFF, then reads 0xFFFF → `req0_ready`=1 on both, and `rsp0_valid`=1 exactly one cycle after the read accept with `rsp0_rdata`=0xA5. `rsp1_valid` stays 0.
- Contention, RR build: both requesters continuously read, no lock → grants alternate 0,1,0,1 starting with req0 after reset. Each `rspN_valid` follows its own grant by one cycle.
- Contention, macro undefined: same stimulus → req0 granted every cycle and req1 starved.
- Locked burst with MAX_BURST=4: req0 asserts lock with 6 writes (0x8000..0x8005) while req1 is valid → req0 gets 4 consecutive grants, req1 gets the 5th cycle, and req0 resumes afterwards. All six addresses read back correctly.
- Lock release: req0 locks, then drops `valid` for one cycle → req1 is granted that same cycle and state returns to `IDLE`/`OWN1` per req1's lock.
- Reset mid-burst: assert `rst_n`=0 for one edge during a req1 locked read stream → the next cycle has `rsp1_valid`=0, and the first post-reset contention is won by req0.
